// File: rtl/trig_link_serializer.sv
// Trigger-word to link-byte serializer.
// Buffers 32-bit trigger words in a small FIFO and emits each word MSB-first
// as four bytes on the link stream. The trigger input is never backpressured:
// a word that finds the FIFO full is dropped and counted instead.
//
// Handshake: a transfer happens on a rising ifclk edge where valid and ready
// are both high. A source holding valid high keeps its data and last stable
// until that transfer. valid never depends on ready.
module trig_link_serializer #(
  parameter int                FIFO_DEPTH    = 16,
  parameter int                DROP_CNT_BITS = 16,
  parameter logic [8*16-1:0]   IFCLKTYPE     = "NONE"
) (
  input  logic                          ifclk,
  input  logic                          ifclk_rst_i,
  input  logic                          runrst_i,
  input  logic [31:0]                   s_trig_tdata,
  input  logic                          s_trig_tvalid,
  output logic                          s_trig_tready,
  output logic [7:0]                    m_link_tdata,
  output logic                          m_link_tvalid,
  input  logic                          m_link_tready,
  output logic                          m_link_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [DROP_CNT_BITS-1:0]      drop_count_o,
  output logic                          overflow_o,
  output logic [0:0]                    dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [AW:0]              FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]              CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]            PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_BITS-1:0] DROP_ONE = {{(DROP_CNT_BITS-1){1'b0}}, 1'b1};

  // The clock tag only matters to timing constraints; folded into a sink.
  logic unused_clk_tag;
  assign unused_clk_tag = ^IFCLKTYPE;

  logic                     tready_q;
  logic [31:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [0:0]               state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [31:0]              shift_q, shift_d;
  logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
  logic                     ovf_q, ovf_d;

  logic beat, fifo_empty, fifo_full, link_hs, word_done, pop, push, drop;

  // Input acceptance, FIFO push/pop and drop decisions.
  always_comb begin
    beat       = s_trig_tvalid & tready_q & ~runrst_i;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    link_hs    = (state_q == ST_SEND) & m_link_tready;
    word_done  = link_hs & (idx_q == 2'd3);
    // A run reset empties the FIFO, so nothing is popped on that cycle.
    pop        = ~runrst_i & ~fifo_empty & ((state_q == ST_IDLE) | word_done);
    push       = beat & (~fifo_full | pop);
    drop       = beat & fifo_full & ~pop;
  end

  // FIFO pointer/occupancy and statistics next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (runrst_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_ONE;
      end
    end
  end

  // Serializer FSM: load a word, then shift out one byte per link transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      idx_d   = 2'd0;
      state_d = ST_SEND;
    end else if (link_hs) begin
      if (idx_q == 2'd3) begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end else begin
        idx_d   = idx_q + 2'd1;
        shift_d = {shift_q[23:0], 8'h00};
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge ifclk) begin
    if (push) mem_q[wr_ptr_q] <= s_trig_tdata;
  end

  // State registers with synchronous reset.
  always_ff @(posedge ifclk) begin
    if (ifclk_rst_i) begin
      tready_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      shift_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign s_trig_tready = tready_q;
  assign m_link_tvalid = (state_q == ST_SEND);
  assign m_link_tdata  = shift_q[31:24];
  assign m_link_tlast  = (state_q == ST_SEND) & (idx_q == 2'd3);
  assign fifo_count_o  = count_q;
  assign drop_count_o  = drop_q;
  assign overflow_o    = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_trig_link_serializer.sv
// Bench for trig_link_serializer: per-cycle vector table for latency,
// stall and back-to-back behaviour, plus sequences for overflow, run reset,
// counter saturation and reset in the middle of a word.
module tb_trig_link_serializer;

  localparam int DEPTH = 16;
  localparam int DCB   = 4;

  logic              ifclk;
  logic              ifclk_rst_i;
  logic              runrst_i;
  logic [31:0]       s_trig_tdata;
  logic              s_trig_tvalid;
  logic              s_trig_tready;
  logic [7:0]        m_link_tdata;
  logic              m_link_tvalid;
  logic              m_link_tready;
  logic              m_link_tlast;
  logic [4:0]        fifo_count_o;
  logic [DCB-1:0]    drop_count_o;
  logic              overflow_o;
  logic [0:0]        dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  trig_link_serializer #(
    .FIFO_DEPTH(DEPTH),
    .DROP_CNT_BITS(DCB),
    .IFCLKTYPE("NONE")
  ) dut (
    .ifclk(ifclk),
    .ifclk_rst_i(ifclk_rst_i),
    .runrst_i(runrst_i),
    .s_trig_tdata(s_trig_tdata),
    .s_trig_tvalid(s_trig_tvalid),
    .s_trig_tready(s_trig_tready),
    .m_link_tdata(m_link_tdata),
    .m_link_tvalid(m_link_tvalid),
    .m_link_tready(m_link_tready),
    .m_link_tlast(m_link_tlast),
    .fifo_count_o(fifo_count_o),
    .drop_count_o(drop_count_o),
    .overflow_o(overflow_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge ifclk);
    @(negedge ifclk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_trig_tvalid = 1'b1;
      s_trig_tdata  = base + 32'(i);
      tick();
    end
    s_trig_tvalid = 1'b0;
    s_trig_tdata  = '0;
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back({1'b0, w[31:24]});
    exp_q.push_back({1'b0, w[23:16]});
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  // Holds tready high and compares every shown byte against exp_q.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    m_link_tready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      if (m_link_tvalid) check(name, {23'd0, m_link_tlast, m_link_tdata}, {23'd0, exp_q.pop_front()});
      tick();
      n++;
    end
    check({name, "_budget"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Vector table
  typedef struct {
    logic        in_v;
    logic [31:0] in_d;
    logic        rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic        e_l;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic r,
                              input logic ev, input logic [7:0] ed, input logic el,
                              input logic [4:0] ec);
    vec_t v;
    v.in_v = iv; v.in_d = id; v.rdy = r;
    v.e_v = ev; v.e_d = ed; v.e_l = el; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    logic pulsed;
    int   n;

    // single word latency
    vecs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hA1, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hB2, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hC3, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hD4, 1, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 5'd0));
    // backpressure on B2 for 5 cycles
    vecs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hA1, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hB2, 0, 5'd0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 32'h0, 0, 1, 8'hB2, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hC3, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'hD4, 1, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 5'd0));
    // back-to-back four words
    vecs.push_back(mk(1, 32'h01020304, 1, 0, 8'h00, 0, 5'd1));
    vecs.push_back(mk(1, 32'h05060708, 1, 1, 8'h01, 0, 5'd1));
    vecs.push_back(mk(1, 32'h090A0B0C, 1, 1, 8'h02, 0, 5'd2));
    vecs.push_back(mk(1, 32'h0D0E0F10, 1, 1, 8'h03, 0, 5'd3));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h04, 1, 5'd3));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h05, 0, 5'd2));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h06, 0, 5'd2));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h07, 0, 5'd2));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h08, 1, 5'd2));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h09, 0, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0A, 0, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0B, 0, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0C, 1, 5'd1));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0D, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0E, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h0F, 0, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 1, 8'h10, 1, 5'd0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 8'h00, 0, 5'd0));

    // reset
    ifclk_rst_i   = 1'b1;
    runrst_i      = 1'b0;
    s_trig_tdata  = '0;
    s_trig_tvalid = 1'b0;
    m_link_tready = 1'b0;
    repeat (3) tick();
    check("rst_tready", {31'd0, s_trig_tready}, 32'd0);
    check("rst_tvalid", {31'd0, m_link_tvalid}, 32'd0);
    check("rst_tdata",  {24'd0, m_link_tdata},  32'd0);
    check("rst_tlast",  {31'd0, m_link_tlast},  32'd0);
    check("rst_count",  {27'd0, fifo_count_o},  32'd0);
    check("rst_drop",   {28'd0, drop_count_o},  32'd0);
    check("rst_ovf",    {31'd0, overflow_o},    32'd0);
    check("rst_state",  {31'd0, dbg_state_o},   32'd0);
    ifclk_rst_i = 1'b0;
    tick();
    check("rst_release_tready", {31'd0, s_trig_tready}, 32'd1);

    // table: apply row inputs, advance one cycle, compare
    for (int i = 0; i < vecs.size(); i++) begin
      s_trig_tvalid = vecs[i].in_v;
      s_trig_tdata  = vecs[i].in_d;
      m_link_tready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, m_link_tvalid}, {31'd0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        check($sformatf("vec%0d_data", i), {24'd0, m_link_tdata}, {24'd0, vecs[i].e_d});
        check($sformatf("vec%0d_last", i), {31'd0, m_link_tlast}, {31'd0, vecs[i].e_l});
      end
      check($sformatf("vec%0d_count", i), {27'd0, fifo_count_o}, {27'd0, vecs[i].e_cnt});
      check($sformatf("vec%0d_drop", i),  {28'd0, drop_count_o}, 32'd0);
      check($sformatf("vec%0d_tready", i), {31'd0, s_trig_tready}, 32'd1);
    end
    s_trig_tvalid = 1'b0;

    // overflow: 20 words with link stalled
    m_link_tready = 1'b0;
    push_words(32'hC0DE0000, 20);
    tick();
    check("ovf_count", {27'd0, fifo_count_o}, 32'd16);
    check("ovf_drop",  {28'd0, drop_count_o}, 32'd3);
    check("ovf_flag",  {31'd0, overflow_o},   32'd1);
    check("ovf_shifter_valid", {31'd0, m_link_tvalid}, 32'd1);
    for (int i = 0; i < 17; i++) expect_word(32'hC0DE0000 + 32'(i));
    drain("ovf_order", 200);
    check("ovf_end_valid", {31'd0, m_link_tvalid}, 32'd0);
    check("ovf_end_count", {27'd0, fifo_count_o}, 32'd0);

    // run reset clears stats
    runrst_i = 1'b1;
    tick();
    runrst_i = 1'b0;
    check("runrst_drop", {28'd0, drop_count_o}, 32'd0);
    check("runrst_ovf",  {31'd0, overflow_o},   32'd0);

    // run reset in the middle of a word with 3 words queued and 5 drops
    m_link_tready = 1'b0;
    push_words(32'h5A000000, 22);
    check("rr_pre_drop",  {28'd0, drop_count_o}, 32'd5);
    check("rr_pre_count", {27'd0, fifo_count_o}, 32'd16);
    for (int i = 0; i < 14; i++) expect_word(32'h5A000000 + 32'(i));
    pulsed = 1'b0;
    n = 0;
    m_link_tready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      if (m_link_tvalid) check("rr_bytes", {23'd0, m_link_tlast, m_link_tdata}, {23'd0, exp_q.pop_front()});
      if (!pulsed && fifo_count_o == 5'd3) begin
        runrst_i = 1'b1;
        pulsed   = 1'b1;
      end else begin
        runrst_i = 1'b0;
      end
      tick();
      n++;
    end
    runrst_i = 1'b0;
    check("rr_budget", 32'(exp_q.size()), 32'd0);
    check("rr_pulsed", {31'd0, pulsed}, 32'd1);
    check("rr_idle_valid", {31'd0, m_link_tvalid}, 32'd0);
    check("rr_count", {27'd0, fifo_count_o}, 32'd0);
    check("rr_drop",  {28'd0, drop_count_o}, 32'd0);
    check("rr_ovf",   {31'd0, overflow_o},   32'd0);
    tick();
    check("rr_stays_idle", {31'd0, m_link_tvalid}, 32'd0);

    // drop counter saturation (4-bit counter)
    m_link_tready = 1'b0;
    push_words(32'h77000000, 37);
    check("sat_drop", {28'd0, drop_count_o}, 32'd15);
    check("sat_ovf",  {31'd0, overflow_o},   32'd1);
    push_words(32'h78000000, 3);
    check("sat_drop_held", {28'd0, drop_count_o}, 32'd15);

    // reset in the middle of a word
    m_link_tready = 1'b1;
    tick();
    tick();
    check("midrst_pre_data", {24'd0, m_link_tdata}, 32'h00000000);
    check("midrst_pre_valid", {31'd0, m_link_tvalid}, 32'd1);
    ifclk_rst_i = 1'b1;
    tick();
    check("midrst_tvalid", {31'd0, m_link_tvalid}, 32'd0);
    check("midrst_tdata",  {24'd0, m_link_tdata},  32'd0);
    check("midrst_tlast",  {31'd0, m_link_tlast},  32'd0);
    check("midrst_tready", {31'd0, s_trig_tready}, 32'd0);
    check("midrst_count",  {27'd0, fifo_count_o}, 32'd0);
    check("midrst_drop",   {28'd0, drop_count_o}, 32'd0);
    check("midrst_ovf",    {31'd0, overflow_o},   32'd0);
    ifclk_rst_i = 1'b0;
    tick();
    check("postrst_tready", {31'd0, s_trig_tready}, 32'd1);
    check("postrst_tvalid", {31'd0, m_link_tvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
